// File: rtl/sign_handler_stream.sv
// Streaming CORDIC quadrant sign handler: applies saturating sign correction to
// first-quadrant cos/sin and emits one or two beats per transaction into a show-ahead FIFO.
module sign_handler_stream #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned LEVEL_IN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_kuadran,
  input  logic                         in_neg,
  input  logic [WIDTH-1:0]             in_cos,
  input  logic [WIDTH-1:0]             in_sin,
  input  logic [1:0]                   in_mode,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_last,
  output logic                         out_sat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             last;
    logic             sat;
  } beat_t;

  typedef enum logic {IDLE, SECOND} state_t;

  // Conditional negation; the most negative value clamps to the most positive one.
  function automatic beat_t correct(input logic [WIDTH-1:0] v, input logic do_neg,
                                    input logic [TAG_W-1:0] tag, input logic last);
    beat_t b;
    b.data = v;
    b.tag  = tag;
    b.last = last;
    b.sat  = 1'b0;
    if (do_neg) begin
      if (v == MIN_VAL) begin
        b.data = MAX_VAL;
        b.sat  = 1'b1;
      end else begin
        b.data = (~v) + WIDTH'(1);
      end
    end
    return b;
  endfunction

  state_t           state;
  beat_t            second_q;
  beat_t            cos_beat;
  beat_t            sin_beat;
  beat_t            first_beat;
  beat_t            second_d;
  beat_t            push_beat;
  beat_t            head;
  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             eff_valid;
  logic             space;
  logic             accept;
  logic             push;
  logic             pop;
  logic             neg_cos;
  logic             neg_sin;
  logic             first_is_sin;

  assign neg_cos      = in_kuadran[0] ^ in_kuadran[1];
  assign neg_sin      = in_neg ^ in_kuadran[1];
  assign first_is_sin = in_mode[0] ^ in_mode[1];

  assign cos_beat   = correct(in_cos, neg_cos, in_tag, ~in_mode[1]);
  assign sin_beat   = correct(in_sin, neg_sin, in_tag, ~in_mode[1]);
  assign first_beat = first_is_sin ? sin_beat : cos_beat;

  // The beat held back for dual-result modes always closes the transaction.
  always_comb begin
    second_d      = first_is_sin ? cos_beat : sin_beat;
    second_d.last = 1'b1;
  end

  // Occupancy is checked before any same-cycle pop, so a full FIFO never falls through.
  assign space     = (count < CNT_W'(DEPTH));
  assign in_ready  = (state == IDLE) && space;
  assign accept    = eff_valid && in_ready;
  assign push      = accept || ((state == SECOND) && space);
  assign push_beat = (state == SECOND) ? second_q : first_beat;
  assign pop       = out_valid && out_ready;

  generate
    if (LEVEL_IN != 0) begin : g_level
      logic valid_q;
      logic armed;
      logic pending;

      // armed suppresses a done level that is already high when reset releases.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          armed   <= 1'b0;
          pending <= 1'b0;
        end else begin
          valid_q <= in_valid;
          armed   <= 1'b1;
          if (in_valid && !valid_q && armed) begin
            pending <= 1'b1;
          end else if (accept) begin
            pending <= 1'b0;
          end
        end
      end

      assign eff_valid = pending;
    end else begin : g_handshake
      assign eff_valid = in_valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      second_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && in_mode[1]) begin
            state    <= SECOND;
            second_q <= second_d;
          end
        end
        SECOND: begin
          if (space) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Show-ahead FIFO storage and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_data  = head.data;
  assign out_tag   = head.tag;
  assign out_last  = head.last;
  assign out_sat   = head.sat;

endmodule
